// File: rtl/fetch_pkg.sv
// Shared constants and types for the Beta instruction-fetch stage.
// Defines the next-PC source encoding, the handler vectors and the fetch queue entry type.
package fetch_pkg;

   typedef enum logic [2:0] {
      PC_SRC_INC   = 3'd0,
      PC_SRC_BR    = 3'd1,
      PC_SRC_JMP   = 3'd2,
      PC_SRC_ILLOP = 3'd3,
      PC_SRC_XADR  = 3'd4
   } pc_src_e;

   localparam logic [31:0] RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

   // ADD(R31, R31, R31)
   localparam logic [31:0] INST_NOP  = 32'h83FF_F800;

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } q_entry_t;

   // Supervisor bit (PC[31]) may be kept or dropped by a redirect, never gained except via a vector.
   function automatic logic [31:0] redirect_target(
      input pc_src_e     sel,
      input logic [31:0] cur_pc,
      input logic [31:0] br_addr,
      input logic [31:0] j_addr
   );
      logic [31:0] target;
      target = XADR_VEC;
      case (sel)
         PC_SRC_BR:    target = {cur_pc[31], br_addr[30:2], 2'b00};
         PC_SRC_JMP:   target = {cur_pc[31] & j_addr[31], j_addr[30:2], 2'b00};
         PC_SRC_ILLOP: target = ILLOP_VEC;
         PC_SRC_XADR:  target = XADR_VEC;
         default:      target = XADR_VEC;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {pc+4, instruction} pairs.
// Flush has priority over push and pop; callers never push when full or pop when empty.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  q_entry_t   push_data,
   output logic [1:0] count,
   output q_entry_t   head
);

   q_entry_t   mem_q [2];
   q_entry_t   mem_d [2];
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// Beta instruction-fetch stage: owns the fetch PC, issues in-order memory requests,
// buffers responses in a 2-entry queue and drops responses made stale by a redirect.
module fetch
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  pc_sel,
   input  logic [31:0] br_addr,
   input  logic [31:0] j_addr,
   input  logic        stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        ir_valid
);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [31:0]      pc_out_q, pc_out_d;
   logic [CNT_W-1:0] in_flight_q, in_flight_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   pc_src_e     sel;
   logic        redirect;
   logic [31:0] target;
   logic [1:0]  q_count;
   q_entry_t    q_head;
   q_entry_t    q_push_data;
   logic        q_empty;
   logic        q_push;
   logic        q_pop;
   logic        req_fire;
   logic        rsp_keep;
   logic [3:0]  credit_use;

   assign sel      = pc_src_e'(pc_sel);
   assign redirect = (sel != PC_SRC_INC);
   assign target   = redirect_target(sel, fetch_pc_q, br_addr, j_addr);
   assign q_empty  = (q_count == 2'd0);
   assign q_pop    = ~stall & ~q_empty & ~redirect;

   // Credit counts live responses plus queued entries; a head popped this cycle
   // frees its slot, which keeps zero-wait memory streaming at one per cycle.
   assign credit_use = {1'b0, in_flight_q - drop_cnt_q} + {2'b00, q_count} - {3'b000, q_pop};
   assign imem_req_valid = rst_n & ~redirect & (credit_use < 4'd2) & (in_flight_q != CNT_MAX);
   assign imem_addr      = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign rsp_keep    = imem_rsp_valid & ~redirect & (drop_cnt_q == '0);
   assign q_push      = rsp_keep;
   assign q_push_data = '{pc4: rsp_pc_q + 32'd4, instr: imem_rsp_data};

   fetch_queue u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (q_push),
      .pop       (q_pop),
      .push_data (q_push_data),
      .count     (q_count),
      .head      (q_head)
   );

   // rsp_pc tracks the address of the next kept response: requests since the
   // last redirect are contiguous, so it simply restarts at the target.
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      rsp_pc_d    = rsp_pc_q;
      in_flight_d = in_flight_q + {{(CNT_W-1){1'b0}}, req_fire}
                                - {{(CNT_W-1){1'b0}}, imem_rsp_valid};
      drop_cnt_d  = drop_cnt_q;

      if (redirect) begin
         fetch_pc_d = target;
         rsp_pc_d   = target;
         drop_cnt_d = in_flight_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      ir_valid = ~redirect & ~q_empty;
      ir       = INST_NOP;
      pc       = pc_out_q;
      if (ir_valid) begin
         ir = q_head.instr;
         pc = q_head.pc4;
      end
      pc_out_d = pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q  <= RESET_VEC;
         rsp_pc_q    <= RESET_VEC;
         pc_out_q    <= '0;
         in_flight_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         rsp_pc_q    <= rsp_pc_d;
         pc_out_q    <= pc_out_d;
         in_flight_q <= in_flight_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   a_rsp_needs_request: assert property (
      @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (in_flight_q != '0)
   );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: a vector table for streaming and stall,
// plus hand-written redirect sequences, against an in-order addr-as-data memory.
module tb_fetch;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [2:0]  pc_sel;
   logic [31:0] br_addr;
   logic [31:0] j_addr;
   logic        stall;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] ir;
   logic [31:0] pc;
   logic        ir_valid;

   logic        mem_hold;
   logic [31:0] mem_q[$];

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] B = 32'h8000_0000;

   typedef struct {
      logic        stall;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_irv;
      logic [31:0] exp_ir;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[13];

   fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_sel         (pc_sel),
      .br_addr        (br_addr),
      .j_addr         (j_addr),
      .stall          (stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ir             (ir),
      .pc             (pc),
      .ir_valid       (ir_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers accepted requests in order, one cycle later, unless held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_addr);
         if (!mem_hold && mem_q.size() > 0) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_q.pop_front();
         end else begin
            imem_rsp_valid <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] br, input logic [31:0] jv,
                                input logic st, input logic rdy, input logic hld);
      @(negedge clk);
      pc_sel         = sel;
      br_addr        = br;
      j_addr         = jv;
      stall          = st;
      imem_req_ready = rdy;
      mem_hold       = hld;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      pc_sel         = PC_SRC_INC;
      br_addr        = '0;
      j_addr         = '0;
      stall          = 1'b0;
      imem_req_ready = 1'b1;
      mem_hold       = 1'b0;
      #1;
      checkOutput("rst.rv",   {31'd0, imem_req_valid}, 32'd0);
      checkOutput("rst.irv",  {31'd0, ir_valid}, 32'd0);
      checkOutput("rst.ir",   ir, INST_NOP);
      checkOutput("rst.pc",   pc, 32'd0);
      checkOutput("rst.addr", imem_addr, RESET_VEC);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic inc(input logic st, input logic rdy, input logic hld);
      applyStimulus(PC_SRC_INC, 32'd0, 32'd0, st, rdy, hld);
   endtask

   initial begin
      rst_n = 1'b0;
      pc_sel = PC_SRC_INC; br_addr = '0; j_addr = '0;
      stall = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0;

      vecs[0]  = '{1'b0, 1'b1, B,          1'b0, INST_NOP,   32'd0};
      vecs[1]  = '{1'b0, 1'b1, B + 32'h04, 1'b0, INST_NOP,   32'd0};
      vecs[2]  = '{1'b0, 1'b1, B + 32'h08, 1'b1, B,          B + 32'h04};
      vecs[3]  = '{1'b0, 1'b1, B + 32'h0C, 1'b1, B + 32'h04, B + 32'h08};
      for (int i = 4; i < 9; i++)
         vecs[i] = '{1'b1, 1'b0, B + 32'h10, 1'b1, B + 32'h08, B + 32'h0C};
      vecs[9]  = '{1'b0, 1'b1, B + 32'h10, 1'b1, B + 32'h08, B + 32'h0C};
      vecs[10] = '{1'b0, 1'b1, B + 32'h14, 1'b1, B + 32'h0C, B + 32'h10};
      vecs[11] = '{1'b0, 1'b1, B + 32'h18, 1'b1, B + 32'h10, B + 32'h14};
      vecs[12] = '{1'b0, 1'b1, B + 32'h1C, 1'b1, B + 32'h14, B + 32'h18};

      // Streaming from reset, with a five-cycle stall in the middle
      do_reset();
      for (int i = 0; i < 13; i++) begin
         inc(vecs[i].stall, 1'b1, 1'b0);
         checkOutput($sformatf("v%0d.rv", i),   {31'd0, imem_req_valid}, {31'd0, vecs[i].exp_rv});
         checkOutput($sformatf("v%0d.addr", i), imem_addr, vecs[i].exp_addr);
         checkOutput($sformatf("v%0d.irv", i),  {31'd0, ir_valid}, {31'd0, vecs[i].exp_irv});
         checkOutput($sformatf("v%0d.ir", i),   ir, vecs[i].exp_ir);
         if (vecs[i].exp_irv) checkOutput($sformatf("v%0d.pc", i), pc, vecs[i].exp_pc);
      end

      // BR with two requests outstanding: both stale responses are dropped
      do_reset();
      inc(1'b0, 1'b1, 1'b1);
      inc(1'b0, 1'b1, 1'b1);
      applyStimulus(PC_SRC_BR, 32'h0000_0100, 32'd0, 1'b0, 1'b1, 1'b1);
      checkOutput("br.c3.rv",  {31'd0, imem_req_valid}, 32'd0);
      checkOutput("br.c3.irv", {31'd0, ir_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("br.c4.rv",   {31'd0, imem_req_valid}, 32'd1);
      checkOutput("br.c4.addr", imem_addr, 32'h8000_0100);
      for (int c = 5; c <= 7; c++) begin
         inc(1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("br.c%0d.irv", c), {31'd0, ir_valid}, 32'd0);
         checkOutput($sformatf("br.c%0d.ir", c),  ir, INST_NOP);
      end
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("br.c8.ir", ir, 32'h8000_0100);
      checkOutput("br.c8.pc", pc, 32'h8000_0104);

      // JMP into user mode, then a JMP from user mode cannot regain supervisor
      do_reset();
      applyStimulus(PC_SRC_JMP, 32'd0, 32'h0000_0200, 1'b0, 1'b1, 1'b0);
      checkOutput("jmp.c1.rv", {31'd0, imem_req_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("jmp.c2.addr", imem_addr, 32'h0000_0200);
      applyStimulus(PC_SRC_JMP, 32'd0, 32'h8000_0040, 1'b0, 1'b1, 1'b0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("jmp.c4.rv",   {31'd0, imem_req_valid}, 32'd1);
      checkOutput("jmp.c4.addr", imem_addr, 32'h0000_0040);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("jmp.c5.irv", {31'd0, ir_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("jmp.c6.ir", ir, 32'h0000_0040);
      checkOutput("jmp.c6.pc", pc, 32'h0000_0044);

      // XADR with a queued instruction, an arriving response and stall all at once
      do_reset();
      inc(1'b0, 1'b1, 1'b0);
      inc(1'b0, 1'b1, 1'b0);
      applyStimulus(PC_SRC_XADR, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
      checkOutput("xadr.c3.rv",  {31'd0, imem_req_valid}, 32'd0);
      checkOutput("xadr.c3.irv", {31'd0, ir_valid}, 32'd0);
      checkOutput("xadr.c3.ir",  ir, INST_NOP);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("xadr.c4.addr", imem_addr, XADR_VEC);
      checkOutput("xadr.c4.irv",  {31'd0, ir_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("xadr.c5.irv", {31'd0, ir_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("xadr.c6.ir", ir, XADR_VEC);
      checkOutput("xadr.c6.pc", pc, XADR_VEC + 32'd4);

      // Memory not ready, then ILLOP: the held reset address is never fetched
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         inc(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("rdy.c%0d.addr", c), imem_addr, RESET_VEC);
      end
      applyStimulus(PC_SRC_ILLOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("rdy.c5.rv", {31'd0, imem_req_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("rdy.c6.addr", imem_addr, ILLOP_VEC);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("rdy.c7.irv", {31'd0, ir_valid}, 32'd0);
      inc(1'b0, 1'b1, 1'b0);
      checkOutput("rdy.c8.ir", ir, ILLOP_VEC);
      checkOutput("rdy.c8.pc", pc, ILLOP_VEC + 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the pipelined Beta CPU, directly upstream of `decode`. It owns the fetch PC and issues requests to instruction memory over a valid/ready request port with an in-order response port. It buffers returned instructions in a 2-entry queue and presents `ir`/`pc` (PC+4) to decode, inserting NOPs when empty. It redirects on branch, jump, illegal-op and exception selects, discarding stale in-flight responses.

## Interface
- `RESET_VEC`, 32'h8000_0000, PC after reset
- `ILLOP_VEC`, 32'h8000_0004, illegal-opcode handler
- `XADR_VEC`, 32'h8000_0008, interrupt/exception handler
- `clk  in  1  clock`
- `rst_n  in  1  reset; asynchronous, active-low`
- `pc_sel  in  3  next-PC source: PC_SRC_INC/BR/JMP/ILLOP/XADR`
- `br_addr  in  32  branch target from decode`
- `j_addr  in  32  jump target (RD1) from decode`
- `stall  in  1  decode not accepting this cycle`
- `imem_req_valid  out  1  request valid`
- `imem_req_ready  in  1  memory accepts request`
- `imem_addr  out  32  request word address`
- `imem_rsp_valid  in  1  response valid, in request order, ≥1 cycle after acceptance`
- `imem_rsp_data  in  32  instruction word`
- `ir  out  32  instruction to decode (INST_NOP when none)`
- `pc  out  32  PC+4 of `ir``
- `ir_valid  out  1  `ir` is a real fetched instruction`

## Operation
- Registers: `fetch_pc[31:0]`, `in_flight[1:0]`, `drop_cnt[1:0]`, 2-entry queue of {pc+4, instr}.
- Request fire (`req_fire`) = `imem_req_valid & imem_req_ready`; `imem_addr = fetch_pc`; on fire `fetch_pc += 4`; wraps modulo 2^32.
- Credit: `imem_req_valid = (in_flight - drop_cnt) + q_count < 2` and no redirect this cycle.
- Response: if `drop_cnt != 0`, discard and decrement `drop_cnt`; else push {addr+4, data}. Queue overflow is impossible by credit; response with `in_flight == 0` is a protocol error (assertion).
- `in_flight` next = `in_flight + req_fire - rsp_fire`.
- Output: queue non-empty → `ir` = head instr, `pc` = head pc+4, `ir_valid=1`; empty → `ir=INST_NOP`, `ir_valid=0`, `pc` holds last driven value. Pop when `~stall & ~empty`.
- Redirect (`pc_sel != PC_SRC_INC`), overrides stall:
  - BR: `fetch_pc = {fetch_pc[31], br_addr[30:2], 2'b00}`.
  - JMP: `fetch_pc = {fetch_pc[31] & j_addr[31], j_addr[30:2], 2'b00}`; user mode cannot enter supervisor.
  - ILLOP/XADR: vector, supervisor bit set.
  - Queue flushed; `ir=INST_NOP`, `ir_valid=0` that cycle; no request issued that cycle.
  - `drop_cnt` next = `in_flight + req_fire - rsp_fire`; any response arriving that cycle is discarded. Back-to-back redirects re-evaluate the same formula.
- Priority: reset > redirect > stall > normal.

## Timing
- Reset (async assert): `fetch_pc=RESET_VEC`, queue empty, `in_flight=0`, `drop_cnt=0`, `imem_req_valid=0`, `ir=INST_NOP`, `ir_valid=0`, `pc=0`.
- First cycle after deassert: `imem_req_valid=1`, `imem_addr=RESET_VEC`.
- Zero-wait memory (ready=1, response one cycle later): `ir` valid one cycle after response; sustained 1 instr/cycle.
- Redirect sampled in cycle N → `imem_addr` = target in N+1; first target instr on `ir` no earlier than N+3.
- Stall: queue fills to 2, then requests stop; release resumes with no loss or duplication.
- Reset mid-operation: in-flight responses after deassert are not tracked; memory must also be reset.

## Structure
- `PC_SRC_*`, `INST_NOP`, vector constants in `defines.v` beside existing `IR_SRC_*`/`INST_*` macros.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO with flush, push, pop, count, head outputs.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr-as-data → `imem_addr` 0x80000000, 0x80000004, …; `ir` 0x80000000 with `pc` 0x80000004 on 3rd cycle, then one per cycle.
- Stall held 5 cycles mid-stream → queue holds 2 entries, `imem_req_valid=0`, release yields contiguous sequence with no gaps or repeats.
- BR redirect to 0x00000100 while 2 requests in flight → both responses dropped, next `imem_addr`=0x80000100 (supervisor kept), `ir` NOP until target returns.
- JMP with `j_addr`=0x80000040 from user PC 0x00000200 → `imem_addr`=0x00000040.
- XADR redirect coinciding with a response and a stall → response dropped, `imem_addr`=0x80000008 next cycle, stall ignored.
- `imem_req_ready=0` for 4 cycles, then redirect → `imem_addr` changes to target only after redirect cycle; held address never fetched.
